// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions: the e_alu_op operation encoding used by the control
// unit and every ALU block, the state encoding of the multi-byte sequencer,
// and small op-classification helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

  // Shared operation encoding. Codes 8..14 are recognised by other ALU blocks
  // but not by the byte sequencer; code 15 is unassigned.
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NAND = 4'd5,
    ALU_NOR  = 4'd6,
    ALU_XNOR = 4'd7,
    ALU_SL   = 4'd8,
    ALU_SR   = 4'd9,
    ALU_RA   = 4'd10,
    ALU_RAS  = 4'd11,
    ALU_MUL  = 4'd12,
    ALU_DIV  = 4'd13,
    ALU_MOD  = 4'd14
  } e_alu_op;

  // Multi-byte sequencer states.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } e_seq_state;

  // Ops the byte sequencer can execute one byte at a time.
  function automatic logic is_seq_op(input e_alu_op op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
      ALU_XOR, ALU_NAND, ALU_NOR, ALU_XNOR: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

  // Ops that propagate a carry/borrow between bytes.
  function automatic logic is_carry_op(input e_alu_op op);
    case (op)
      ALU_ADD, ALU_SUB: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_slice.sv
// -----------------------------------------------------------------------------
// alu_seq_slice
// Combinational WORD-wide ALU slice. The sequencer time-multiplexes a single
// instance over the bytes of a wide operand, feeding c_out of one byte back
// as c_in of the next.
// Ports:
//   op     in   operation (only sequencer ops produce a non-zero result)
//   a_i    in   WORD-bit byte of operand A
//   b_i    in   WORD-bit byte of operand B
//   c_in   in   carry in (ADD) / borrow in (SUB); ignored by logic ops
//   r_i    out  WORD-bit byte result
//   c_out  out  carry out (ADD) / borrow out (SUB); 0 for logic ops
// -----------------------------------------------------------------------------
module alu_seq_slice
  import alu_pkg::*;
#(
  parameter int WORD = 8
) (
  input  e_alu_op         op,
  input  logic [WORD-1:0] a_i,
  input  logic [WORD-1:0] b_i,
  input  logic            c_in,
  output logic [WORD-1:0] r_i,
  output logic            c_out
);

  // One extra bit above the byte catches the carry, or the borrow as the
  // sign of a - b - bw (which never drops below -2^WORD).
  logic [WORD:0] ext_s;

  // Byte-wide arithmetic / logic evaluation.
  always_comb begin
    ext_s = {(WORD+1){1'b0}};
    r_i   = {WORD{1'b0}};
    c_out = 1'b0;
    case (op)
      ALU_ADD: begin
        ext_s = {1'b0, a_i} + {1'b0, b_i} + {{WORD{1'b0}}, c_in};
        r_i   = ext_s[WORD-1:0];
        c_out = ext_s[WORD];
      end
      ALU_SUB: begin
        ext_s = {1'b0, a_i} - {1'b0, b_i} - {{WORD{1'b0}}, c_in};
        r_i   = ext_s[WORD-1:0];
        c_out = ext_s[WORD];
      end
      ALU_AND:  r_i = a_i & b_i;
      ALU_OR:   r_i = a_i | b_i;
      ALU_XOR:  r_i = a_i ^ b_i;
      ALU_NAND: r_i = ~(a_i & b_i);
      ALU_NOR:  r_i = ~(a_i | b_i);
      ALU_XNOR: r_i = ~(a_i ^ b_i);
      default: begin
        r_i   = {WORD{1'b0}};
        c_out = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Multi-byte ALU sequencer. Accepts one W = WORD*NBYTES bit operation per
// start handshake, processes it one byte per cycle LSB first with a chained
// carry/borrow, and presents the wide result and flags with a done pulse.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset (aborts a running op)
//   start     in   request; accepted only while busy=0
//   op        in   e_alu_op operation, sampled with start
//   a_in      in   W-bit operand A, sampled with start
//   b_in      in   W-bit operand B, sampled with start
//   cin_in    in   initial carry (ADD) / borrow (SUB), sampled with start
//   sign      in   signed mode, sampled with start
//   busy      out  high while bytes are being processed
//   done      out  one-cycle pulse; result/flags valid from this cycle on
//   result    out  W-bit result, held until the next completed op
//   cout      out  final carry/borrow (0 in signed mode)
//   zero      out  result == 0 over all W bits
//   overflow  out  signed overflow (signed ADD/SUB only)
//   err       out  op not executable by the sequencer
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WORD   = 8,
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  e_alu_op                op,
  input  logic [WORD*NBYTES-1:0] a_in,
  input  logic [WORD*NBYTES-1:0] b_in,
  input  logic                   cin_in,
  input  logic                   sign,
  output logic                   busy,
  output logic                   done,
  output logic [WORD*NBYTES-1:0] result,
  output logic                   cout,
  output logic                   zero,
  output logic                   overflow,
  output logic                   err
);

  localparam int W     = WORD * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  e_seq_state        state_r;
  e_seq_state        state_s;
  e_alu_op           op_r;
  logic [W-1:0]      a_r;        // shifts right one byte per RUN cycle
  logic [W-1:0]      b_r;
  logic [W-1:0]      acc_r;      // result bytes enter at the top, LSB first
  logic [IDX_W-1:0]  idx_r;
  logic              carry_r;
  logic              sign_r;
  logic              bad_r;      // accepted op is not a sequencer op
  logic              a_msb_r;    // operand MSBs kept for the overflow rule
  logic              b_msb_r;

  logic [WORD-1:0]   r_s;
  logic              c_s;
  logic [W+WORD-1:0] acc_cat_s;
  logic              accept_s;
  logic              last_s;
  logic              ov_s;

  alu_seq_slice #(
    .WORD (WORD)
  ) u_slice (
    .op    (op_r),
    .a_i   (a_r[WORD-1:0]),
    .b_i   (b_r[WORD-1:0]),
    .c_in  (carry_r),
    .r_i   (r_s),
    .c_out (c_s)
  );

  // New result byte pushed in at the top; after NBYTES pushes byte 0 sits
  // at the bottom.
  assign acc_cat_s = {r_s, acc_r} >> WORD;
  assign accept_s  = start && ((state_r == SEQ_IDLE) || (state_r == SEQ_DONE));
  assign last_s    = (idx_r == LAST_IDX);

  // Signed overflow from the operand MSBs and the assembled result MSB.
  always_comb begin
    ov_s = 1'b0;
    if (sign_r) begin
      case (op_r)
        ALU_ADD: ov_s = (a_msb_r == b_msb_r) && (acc_r[W-1] != a_msb_r);
        ALU_SUB: ov_s = (a_msb_r != b_msb_r) && (acc_r[W-1] != a_msb_r);
        default: ov_s = 1'b0;
      endcase
    end else begin
      ov_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= SEQ_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic. DONE accepts a new start just like IDLE, giving
  // back-to-back operation.
  always_comb begin
    state_s = state_r;
    case (state_r)
      SEQ_IDLE, SEQ_DONE: begin
        if (start) begin
          if (is_seq_op(op)) begin
            state_s = SEQ_RUN;
          end else begin
            state_s = SEQ_DONE;
          end
        end else begin
          state_s = SEQ_IDLE;
        end
      end
      SEQ_RUN: begin
        if (last_s) begin
          state_s = SEQ_DONE;
        end else begin
          state_s = SEQ_RUN;
        end
      end
      default: state_s = SEQ_IDLE;
    endcase
  end

  // Datapath: operand capture, byte stepping, and output registers that
  // change only when leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r     <= ALU_ADD;
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      carry_r  <= 1'b0;
      sign_r   <= 1'b0;
      bad_r    <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= {W{1'b0}};
      cout     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_s == SEQ_RUN);

      if (state_r == SEQ_RUN) begin
        a_r     <= a_r >> WORD;
        b_r     <= b_r >> WORD;
        acc_r   <= acc_cat_s[W-1:0];
        carry_r <= c_s;
        idx_r   <= idx_r + IDX_W'(1);
        // A supported op is executing, so any earlier error is stale.
        err     <= 1'b0;
      end

      if (state_r == SEQ_DONE) begin
        done     <= 1'b1;
        err      <= bad_r;
        result   <= bad_r ? {W{1'b0}} : acc_r;
        zero     <= bad_r ? 1'b1 : (acc_r == {W{1'b0}});
        cout     <= (!bad_r && !sign_r && is_carry_op(op_r)) ? carry_r : 1'b0;
        overflow <= !bad_r && ov_s;
      end

      if (accept_s) begin
        op_r    <= op;
        a_r     <= a_in;
        b_r     <= b_in;
        acc_r   <= {W{1'b0}};
        idx_r   <= {IDX_W{1'b0}};
        carry_r <= cin_in;
        sign_r  <= sign;
        bad_r   <= !is_seq_op(op);
        a_msb_r <= a_in[W-1];
        b_msb_r <= b_in[W-1];
        // From DONE the error flag belongs to the op completing this edge.
        if (state_r == SEQ_IDLE) begin
          err <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WORD=8, NBYTES=4). A timeline model
// schedules, per clock edge, the expected busy/done values and the wide
// result computed with 64-bit integer arithmetic; a compare process checks
// the DUT against it every cycle. Directed cases with literal expectations
// precede a randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_seq;
  import alu_pkg::*;

  localparam int NB    = 4;
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  e_alu_op     op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin_in;
  logic        sign;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        zero;
  logic        overflow;
  logic        err;

  int errors = 0;
  int checks = 0;
  int edge_cnt = 0;

  // Expected values in the cycle following edge e.
  bit        exp_busy [DEPTH];
  bit        exp_done [DEPTH];
  bit        exp_rst  [DEPTH];
  bit [31:0] exp_res  [DEPTH];
  bit        exp_co   [DEPTH];
  bit        exp_z    [DEPTH];
  bit        exp_ov   [DEPTH];
  bit        exp_er   [DEPTH];

  logic [31:0] h_res;
  logic        h_co, h_z, h_ov;

  always #5 clk = ~clk;

  alu_seq #(.WORD(8), .NBYTES(NB)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .cin_in(cin_in), .sign(sign), .busy(busy), .done(done), .result(result),
    .cout(cout), .zero(zero), .overflow(overflow), .err(err)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Reference result of one wide operation from plain integer arithmetic.
  task automatic predict(input e_alu_op o, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic s,
                         output logic [31:0] r, output logic co, output logic z,
                         output logic ov, output logic er);
    logic [63:0] u;
    longint      sv;
    r = 32'd0; co = 1'b0; ov = 1'b0; er = 1'b0;
    case (o)
      ALU_ADD: begin
        u  = 64'(a) + 64'(b) + 64'(c);
        r  = u[31:0];
        co = u[32];
        sv = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      ALU_SUB: begin
        r  = a - b - 32'(c);
        co = (64'(a) < (64'(b) + 64'(c)));
        sv = longint'($signed(a)) - longint'($signed(b)) - longint'(c);
        ov = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
      end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NAND: r = ~(a & b);
      ALU_NOR:  r = ~(a | b);
      ALU_XNOR: r = ~(a ^ b);
      default:  er = 1'b1;
    endcase
    if (s) co = 1'b0;
    else   ov = 1'b0;
    z = (r == 32'd0);
  endtask

  // Timeline model: interprets inputs at each rising edge.
  initial begin
    logic [31:0] r;
    logic co, z, ov, er;
    int e, d;
    forever begin
      @(posedge clk);
      e = edge_cnt + 1;
      if (e < DEPTH - 8) begin
        if (rst) begin
          exp_rst[e] = 1'b1;
          for (int k = 0; k < 6; k++) begin
            exp_busy[e+k] = 1'b0;
            exp_done[e+k] = 1'b0;
          end
        end else if (start && !exp_busy[e-1]) begin
          predict(op, a_in, b_in, cin_in, sign, r, co, z, ov, er);
          if (er) begin
            d = e + 1;
          end else begin
            d = e + NB + 1;
            for (int k = 0; k < NB; k++) exp_busy[e+k] = 1'b1;
          end
          exp_done[d] = 1'b1;
          exp_res[d]  = r;
          exp_co[d]   = co;
          exp_z[d]    = z;
          exp_ov[d]   = ov;
          exp_er[d]   = er;
        end
      end
      edge_cnt = e;
    end
  end

  // Compare process: every cycle, away from the rising edge.
  initial begin
    int e;
    h_res = 32'd0; h_co = 1'b0; h_z = 1'b0; h_ov = 1'b0;
    forever begin
      @(negedge clk);
      e = edge_cnt;
      if (e > 0 && e < DEPTH - 8) begin
        if (exp_rst[e]) begin
          h_res = 32'd0; h_co = 1'b0; h_z = 1'b0; h_ov = 1'b0;
        end else if (exp_done[e]) begin
          h_res = exp_res[e]; h_co = exp_co[e]; h_z = exp_z[e]; h_ov = exp_ov[e];
        end
        chk($sformatf("cycle@%0d {busy,done,result,cout,zero,ovf}", e),
            {27'd0, busy, done, result, cout, zero, overflow},
            {27'd0, exp_busy[e], exp_done[e], h_res, h_co, h_z, h_ov});
        if (exp_done[e]) chk($sformatf("err@%0d", e), {63'd0, err}, {63'd0, exp_er[e]});
      end
    end
  end

  task automatic issue(input e_alu_op o, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    @(negedge clk);
    start = 1'b1; op = o; a_in = a; b_in = b; cin_in = c; sign = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for done; lat counts cycles after the accepting edge.
  task automatic wait_done(output int lat, output int bcnt);
    lat = -1; bcnt = 0;
    for (int j = 0; j < 20; j++) begin
      if (done) begin
        lat = j;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_op(input string name, input e_alu_op o, input logic [31:0] a,
                          input logic [31:0] b, input logic c, input logic s,
                          input logic [31:0] w_res, input logic w_co, input logic w_z,
                          input logic w_ov, input logic w_er, input int w_lat);
    int lat, bcnt;
    issue(o, a, b, c, s);
    wait_done(lat, bcnt);
    chk({name, " latency"}, 64'(lat), 64'(w_lat));
    chk({name, " busy cycles"}, 64'(bcnt), (w_lat == NB + 1) ? 64'(NB) : 64'd0);
    chk({name, " {result,cout,zero,ovf,err}"},
        {28'd0, result, cout, zero, overflow, err},
        {28'd0, w_res, w_co, w_z, w_ov, w_er});
    @(negedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, bcnt;
    bit seen;
    rst = 1'b1; start = 1'b0; op = ALU_ADD; a_in = 32'd0; b_in = 32'd0;
    cin_in = 1'b0; sign = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset outputs", {25'd0, busy, done, result, cout, zero, overflow, err}, 64'd0);

    check_op("carry chain", ALU_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0100_0000, 1'b0, 1'b0, 1'b0, 1'b0, NB + 1);
    check_op("add wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b0, NB + 1);
    check_op("sub borrow", ALU_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0,
             32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, NB + 1);
    check_op("signed add ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1,
             32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, NB + 1);
    check_op("signed sub ovf", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1,
             32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, NB + 1);
    check_op("add cin", ALU_ADD, 32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0,
             32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, NB + 1);

    // XOR, ignored start at T+2, back-to-back AND started in the DONE cycle.
    @(negedge clk);
    start = 1'b1; op = ALU_XOR; a_in = 32'h1234_5678; b_in = 32'hFFFF_0000;
    cin_in = 1'b0; sign = 1'b0;
    @(negedge clk); start = 1'b0;                       // after edge T
    @(negedge clk);                                     // after T+1
    start = 1'b1; op = ALU_AND; a_in = 32'hFFFF_FFFF; b_in = 32'h0000_0000;
    @(negedge clk); start = 1'b0;                       // after T+2
    @(negedge clk);                                     // after T+3
    @(negedge clk); start = 1'b1;                       // after T+4: DONE cycle
    @(negedge clk); start = 1'b0;                       // after T+5
    chk("xor done", {63'd0, done}, 64'd1);
    chk("xor result", {32'd0, result}, {32'd0, 32'hEDCB_5678});
    @(negedge clk);
    wait_done(lat, bcnt);
    chk("b2b second done gap", 64'(lat + 1), 64'(NB + 1));
    chk("b2b {result,zero}", {31'd0, result, zero}, {31'd0, 32'h0000_0000, 1'b1});
    repeat (2) @(negedge clk);

    check_op("mul unsupported", ALU_MUL, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0,
             32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1);
    check_op("add after err", ALU_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0,
             32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0, NB + 1);
    check_op("unlisted code", e_alu_op'(4'd15), 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0,
             32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1);

    // Reset at edge T+2 aborts the running add.
    issue(ALU_ADD, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort {busy,result}", {31'd0, busy, result}, 64'd0);
    seen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort no done", {63'd0, seen}, 64'd0);
    check_op("add after abort", ALU_ADD, 32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0,
             32'h0000_000B, 1'b0, 1'b0, 1'b0, 1'b0, NB + 1);

    // Randomized phase: random starts (often while busy), ops and resets.
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      rst    = ($urandom_range(0, 149) == 0);
      start  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 4) == 0) op = e_alu_op'(4'($urandom_range(8, 15)));
      else                           op = e_alu_op'(4'($urandom_range(0, 7)));
      a_in   = pick();
      b_in   = pick();
      cin_in = 1'($urandom_range(0, 1));
      sign   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
